adc_port_sched: RTL and testbench

- Time-division scheduler for the ADC port bank feeding the receiver core.
- Walks an enabled-port mask in round-robin order and drives a port select plus qualifying strobes to a downstream mux/accumulator.
- Each port gets a guard (settle) interval, then a programmable dwell.
- Can start on, and optionally re-align to, the synchronized PPS pulse; sits beside trcv in the adc.clk domain.

---
 rtl/adc_sched_pkg.sv | 21 ++
 rtl/adc_port_sched_rr_next_sel.sv | 26 ++
 rtl/adc_port_sched.sv | 172 +++++++++++++++++
 tb/tb_adc_port_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and helpers for the ADC port time-division scheduler.
package adc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SETTLE,
    DWELL
  } sched_state_e;

  // Widest mask the helper accepts; callers zero-extend narrower masks.
  localparam int MAX_PORTS = 64;

  function automatic int unsigned lowest_set(input logic [MAX_PORTS-1:0] m);
    lowest_set = 0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = i;
    end
  endfunction

endpackage

// File: rtl/adc_port_sched_rr_next_sel.sv
// Rotating priority search: next enabled port strictly above cur, else wrap to the lowest.
module rr_next_sel
  import adc_sched_pkg::*;
#(
  parameter int PORTS = 18,
  parameter int SEL_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next_sel,
  output logic             wrap
);

  logic [PORTS-1:0] above;

  always_comb begin
    above = '0;
    for (int i = 0; i < PORTS; i++) begin
      above[i] = mask[i] && (i > int'(cur));
    end
    wrap     = ~|above;
    next_sel = wrap ? SEL_W'(lowest_set(MAX_PORTS'(mask)))
                    : SEL_W'(lowest_set(MAX_PORTS'(above)));
  end

endmodule

// File: rtl/adc_port_sched.sv
// Round-robin ADC port scheduler: guard/settle then dwell per enabled port,
// with optional PPS-gated start and PPS re-alignment.
module adc_port_sched
  import adc_sched_pkg::*;
#(
  parameter int PORTS   = 18,
  parameter int SEL_W   = $clog2(PORTS),
  parameter int DWELL_W = 24,
  parameter int GUARD   = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cfg_en,
  input  logic [PORTS-1:0]   cfg_mask,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_pps_start,
  input  logic               cfg_pps_resync,
  input  logic               pps,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               switch_pulse,
  output logic               cycle_done,
  output logic               busy,
  output logic               err_empty
);

  localparam int GUARD_W = $clog2(GUARD + 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD - 1);

  sched_state_e       state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [PORTS-1:0]   mask_s_q, mask_s_d;
  logic [DWELL_W-1:0] dwell_s_q, dwell_s_d;
  logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               switch_pulse_q, switch_pulse_d;
  logic               cycle_done_q, cycle_done_d;
  logic               err_empty_q, err_empty_d;

  logic [SEL_W-1:0]   run_next, first_sel;
  logic               run_wrap, first_wrap_unused;
  logic [DWELL_W-1:0] dwell_last;
  logic               cfg_mask_zero;
  logic               reload;

  rr_next_sel #(.PORTS(PORTS), .SEL_W(SEL_W)) u_rr_run (
    .mask     (mask_s_q),
    .cur      (sel_q),
    .next_sel (run_next),
    .wrap     (run_wrap)
  );

  // Searching from the top index always wraps, yielding the lowest set bit of the live mask.
  rr_next_sel #(.PORTS(PORTS), .SEL_W(SEL_W)) u_rr_first (
    .mask     (cfg_mask),
    .cur      (SEL_W'(PORTS - 1)),
    .next_sel (first_sel),
    .wrap     (first_wrap_unused)
  );

  assign cfg_mask_zero = ~|cfg_mask;
  assign dwell_last    = (dwell_s_q == '0) ? '0 : dwell_s_q - DWELL_W'(1);

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    mask_s_d       = mask_s_q;
    dwell_s_d      = dwell_s_q;
    guard_cnt_d    = guard_cnt_q;
    dwell_cnt_d    = dwell_cnt_q;
    switch_pulse_d = 1'b0;
    cycle_done_d   = 1'b0;
    err_empty_d    = err_empty_q;
    reload         = 1'b0;

    if (!cfg_en) begin
      state_d     = IDLE;
      err_empty_d = 1'b0;
      guard_cnt_d = '0;
      dwell_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_mask_zero) begin
            err_empty_d = 1'b1;
          end else begin
            reload  = 1'b1;
            state_d = cfg_pps_start ? ARM : SETTLE;
          end
        end
        ARM: begin
          if (pps) state_d = SETTLE;
        end
        SETTLE, DWELL: begin
          // A resync pps wins over a dwell expiry landing on the same cycle.
          if (pps && cfg_pps_resync) begin
            reload = 1'b1;
          end else if (state_q == SETTLE) begin
            if (guard_cnt_q == GUARD_LAST) begin
              guard_cnt_d = '0;
              state_d     = DWELL;
            end else begin
              guard_cnt_d = guard_cnt_q + 1'b1;
            end
          end else if (dwell_cnt_q == dwell_last) begin
            dwell_cnt_d = '0;
            if (run_wrap) begin
              reload       = 1'b1;
              cycle_done_d = 1'b1;
            end else begin
              sel_d          = run_next;
              switch_pulse_d = 1'b1;
              state_d        = SETTLE;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // Shadow reload shared by start, wrap and resync; an empty live mask parks in IDLE.
      if (reload) begin
        guard_cnt_d = '0;
        dwell_cnt_d = '0;
        if (cfg_mask_zero) begin
          state_d      = IDLE;
          err_empty_d  = 1'b1;
          cycle_done_d = 1'b0;
        end else begin
          mask_s_d       = cfg_mask;
          dwell_s_d      = cfg_dwell;
          sel_d          = first_sel;
          switch_pulse_d = 1'b1;
          if (state_q != IDLE) state_d = SETTLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      mask_s_q       <= '0;
      dwell_s_q      <= '0;
      guard_cnt_q    <= '0;
      dwell_cnt_q    <= '0;
      switch_pulse_q <= 1'b0;
      cycle_done_q   <= 1'b0;
      err_empty_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      mask_s_q       <= mask_s_d;
      dwell_s_q      <= dwell_s_d;
      guard_cnt_q    <= guard_cnt_d;
      dwell_cnt_q    <= dwell_cnt_d;
      switch_pulse_q <= switch_pulse_d;
      cycle_done_q   <= cycle_done_d;
      err_empty_q    <= err_empty_d;
    end
  end

  assign sel          = sel_q;
  assign sel_valid    = (state_q == DWELL);
  assign busy         = (state_q != IDLE);
  assign switch_pulse = switch_pulse_q;
  assign cycle_done   = cycle_done_q;
  assign err_empty    = err_empty_q;

endmodule

// File: tb/tb_adc_port_sched.sv
// Self-checking bench for adc_port_sched: per-cycle frame traces built from the
// scheduling rules, plus directed error/pps/reset scenarios.
module tb_adc_port_sched;

  localparam int PORTS   = 18;
  localparam int SEL_W   = 5;
  localparam int DWELL_W = 24;
  localparam int GUARD   = 4;

  typedef struct {
    int sel;
    bit valid;
    bit sw;
    bit done;
  } exp_t;

  logic               clk = 1'b0;
  logic               resetn;
  logic               cfg_en;
  logic [PORTS-1:0]   cfg_mask;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_pps_start;
  logic               cfg_pps_resync;
  logic               pps;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic               switch_pulse;
  logic               cycle_done;
  logic               busy;
  logic               err_empty;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   last_sel = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  adc_port_sched #(
    .PORTS(PORTS), .SEL_W(SEL_W), .DWELL_W(DWELL_W), .GUARD(GUARD)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cfg_en         (cfg_en),
    .cfg_mask       (cfg_mask),
    .cfg_dwell      (cfg_dwell),
    .cfg_pps_start  (cfg_pps_start),
    .cfg_pps_resync (cfg_pps_resync),
    .pps            (pps),
    .sel            (sel),
    .sel_valid      (sel_valid),
    .switch_pulse   (switch_pulse),
    .cycle_done     (cycle_done),
    .busy           (busy),
    .err_empty      (err_empty)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // One frame: each enabled port in ascending order gets GUARD settle cycles then max(d,1) dwell cycles.
  task automatic add_frame(input logic [PORTS-1:0] m, input int d, input bit first);
    bit lead = 1'b1;
    int dw   = (d < 1) ? 1 : d;
    for (int p = 0; p < PORTS; p++) begin
      if (m[p]) begin
        for (int k = 0; k < GUARD; k++)
          q.push_back('{p, 1'b0, (k == 0), (k == 0) && lead && !first});
        for (int k = 0; k < dw; k++)
          q.push_back('{p, 1'b1, 1'b0, 1'b0});
        lead = 1'b0;
      end
    end
  endtask

  task automatic check_entry(input exp_t e, input string ctx);
    check_val({ctx, " sel"},          32'(sel),          32'(e.sel));
    check_val({ctx, " sel_valid"},    32'(sel_valid),    32'(e.valid));
    check_val({ctx, " switch_pulse"}, 32'(switch_pulse), 32'(e.sw));
    check_val({ctx, " cycle_done"},   32'(cycle_done),   32'(e.done));
    check_val({ctx, " busy"},         32'(busy),         32'd1);
    last_sel = e.sel;
  endtask

  task automatic check_trace(input int n, input string ctx);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      step_clk();
      e = q.pop_front();
      check_entry(e, ctx);
    end
  endtask

  task automatic stop_run(input string ctx);
    cfg_en = 1'b0;
    step_clk();
    check_val({ctx, " stop busy"},      32'(busy),      32'd0);
    check_val({ctx, " stop sel_valid"}, 32'(sel_valid), 32'd0);
    check_val({ctx, " stop sel_hold"},  32'(sel),       32'(last_sel));
    check_val({ctx, " stop err_empty"}, 32'(err_empty), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t             e;
    logic [PORTS-1:0] m;
    int               d;
    bit               found;

    resetn = 1'b0; cfg_en = 1'b0; cfg_mask = '0; cfg_dwell = DWELL_W'(3);
    cfg_pps_start = 1'b0; cfg_pps_resync = 1'b0; pps = 1'b0;
    #2;
    check_val("reset sel",          32'(sel),          32'd0);
    check_val("reset sel_valid",    32'(sel_valid),    32'd0);
    check_val("reset switch_pulse", 32'(switch_pulse), 32'd0);
    check_val("reset cycle_done",   32'(cycle_done),   32'd0);
    check_val("reset busy",         32'(busy),         32'd0);
    check_val("reset err_empty",    32'(err_empty),    32'd0);
    #20 resetn = 1'b1;
    step_clk();

    // Two-port frame, 14-cycle period.
    $display("[TB] mask 0x5 dwell 3");
    cfg_mask = 18'h00005; cfg_dwell = DWELL_W'(3); cfg_en = 1'b1;
    q.delete();
    add_frame(18'h00005, 3, 1'b1); add_frame(18'h00005, 3, 1'b0); add_frame(18'h00005, 3, 1'b0);
    check_trace(q.size(), "mask5");
    stop_run("mask5");

    $display("[TB] empty mask");
    cfg_mask = '0; cfg_en = 1'b1;
    step_clk();
    check_val("empty err_empty", 32'(err_empty), 32'd1);
    check_val("empty busy",      32'(busy),      32'd0);
    step_clk();
    check_val("empty err_sticky", 32'(err_empty), 32'd1);
    cfg_en = 1'b0;
    step_clk();
    check_val("empty err_clear", 32'(err_empty), 32'd0);

    $display("[TB] pps start, port 17");
    cfg_mask = 18'h20000; cfg_dwell = DWELL_W'(2); cfg_pps_start = 1'b1; cfg_en = 1'b1;
    step_clk();
    check_val("arm sel",    32'(sel),          32'd17);
    check_val("arm switch", 32'(switch_pulse), 32'd1);
    check_val("arm busy",   32'(busy),         32'd1);
    check_val("arm valid",  32'(sel_valid),    32'd0);
    for (int i = 0; i < 5; i++) begin
      step_clk();
      check_val("arm wait valid",  32'(sel_valid),    32'd0);
      check_val("arm wait switch", 32'(switch_pulse), 32'd0);
      check_val("arm wait sel",    32'(sel),          32'd17);
    end
    pps = 1'b1;
    step_clk();
    pps = 1'b0;
    q.delete();
    add_frame(18'h20000, 2, 1'b1); add_frame(18'h20000, 2, 1'b0);
    e = q.pop_front();
    e.sw = 1'b0;
    check_entry(e, "pps_start");
    check_trace(q.size(), "pps_start");
    stop_run("pps_start");
    cfg_pps_start = 1'b0;

    $display("[TB] resync colliding with dwell expiry");
    cfg_mask = 18'h0000F; cfg_dwell = DWELL_W'(10); cfg_pps_resync = 1'b1; cfg_en = 1'b1;
    q.delete();
    add_frame(18'h0000F, 10, 1'b1);
    found = 1'b0;
    while (q.size() > 1 && !found) begin
      step_clk();
      e = q.pop_front();
      check_entry(e, "resync pre");
      if (e.sel == 2 && e.valid && q[0].sw) found = 1'b1;
    end
    check_val("resync last_dwell_reached", 32'(found), 32'd1);
    pps = 1'b1;
    step_clk();
    pps = 1'b0;
    q.delete();
    add_frame(18'h0000F, 10, 1'b1); add_frame(18'h0000F, 10, 1'b0);
    e = q.pop_front();
    check_entry(e, "resync hit");
    check_trace(q.size(), "resync post");
    cfg_mask = '0; pps = 1'b1;
    step_clk();
    pps = 1'b0;
    check_val("resync empty busy",  32'(busy),      32'd0);
    check_val("resync empty err",   32'(err_empty), 32'd1);
    check_val("resync empty valid", 32'(sel_valid), 32'd0);
    cfg_en = 1'b0;
    step_clk();
    check_val("resync empty err_clear", 32'(err_empty), 32'd0);
    cfg_pps_resync = 1'b0;

    // Mid-frame mask change only takes effect at the wrap.
    $display("[TB] mask change 0x3 -> 0xC");
    cfg_mask = 18'h00003; cfg_dwell = DWELL_W'(2); cfg_en = 1'b1;
    q.delete();
    add_frame(18'h00003, 2, 1'b1); add_frame(18'h0000C, 2, 1'b0); add_frame(18'h0000C, 2, 1'b0);
    check_trace(1, "maskchg");
    cfg_mask = 18'h0000C;
    check_trace(q.size(), "maskchg");
    stop_run("maskchg");

    $display("[TB] async reset mid-dwell");
    m = 18'h000A4; cfg_mask = m; cfg_dwell = DWELL_W'(3); cfg_en = 1'b1;
    q.delete();
    add_frame(m, 3, 1'b1);
    check_trace(GUARD + 1, "rst pre");
    #2 resetn = 1'b0;
    #1;
    check_val("rst sel",    32'(sel),          32'd0);
    check_val("rst valid",  32'(sel_valid),    32'd0);
    check_val("rst busy",   32'(busy),         32'd0);
    check_val("rst switch", 32'(switch_pulse), 32'd0);
    check_val("rst done",   32'(cycle_done),   32'd0);
    #2 resetn = 1'b1;
    q.delete();
    add_frame(m, 3, 1'b1); add_frame(m, 3, 1'b0);
    check_trace(q.size(), "rst post");
    stop_run("rst post");

    $display("[TB] randomized frames");
    for (int i = 0; i < 8; i++) begin
      m = 18'($urandom_range(1, (1 << PORTS) - 1));
      d = int'($urandom_range(0, 5));
      if (i == 0) begin m = 18'h20001; d = 0; end
      if (i == 1) begin m = '1; d = 1; end
      cfg_mask = m; cfg_dwell = DWELL_W'(d); cfg_en = 1'b1;
      q.delete();
      add_frame(m, d, 1'b1); add_frame(m, d, 1'b0);
      check_trace(q.size(), "rand");
      stop_run("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
